// File: rtl/rst_sequencer.sv
// rst_sequencer: brings per-subsystem resets out one stage at a time.
// A stage is released only after a programmable delay. The next stage is not
// started until the current stage acknowledges init-done.
// A missing ack, or ack loss after full bring-up, raises a sticky fault.
module rst_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 1024,
  parameter int ACK_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_n_i,
  input  logic                  pll_locked_i,
  input  logic                  soft_rst_req_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  all_ready_o,
  output logic                  seq_busy_o,
  output logic                  fault_o,
  output logic [2:0]            fault_stage_o
);

  typedef enum logic [2:0] {S_HOLD, S_DELAY, S_WAIT_ACK, S_READY, S_FAULT} state_e;

  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sync1_q, locked_s_q;
  logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  fault_q, fault_d;
  logic [2:0]            fstage_q, fstage_d;

  // Ack vector widened to 8 bits so the 3-bit stage index can select it directly.
  logic [7:0] ack_pad;
  logic [2:0] low_idx;
  assign ack_pad = 8'(stage_ack_i);

  // Lowest deasserted ack, used when a stage drops its ack after full bring-up.
  always_comb begin
    low_idx = 3'd0;
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (!stage_ack_i[i]) low_idx = 3'(i);
  end

  // State register, two-flop lock synchroniser and registered outputs.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      state_q    <= S_HOLD;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      rst_n_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      fstage_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sync1_q    <= pll_locked_i;
      locked_s_q <= sync1_q;
      rst_n_q    <= rst_n_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      fstage_q   <= fstage_d;
    end
  end

  // Next state. Lock loss beats a soft request, which beats normal sequencing.
  // Status outputs are derived from the next state so they line up with it.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rst_n_d  = rst_n_q;
    fault_d  = fault_q;
    fstage_d = fstage_q;

    if (!locked_s_q && state_q != S_HOLD) begin
      state_d = S_HOLD;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else if (soft_rst_req_i) begin
      state_d  = S_HOLD;
      idx_d    = 3'd0;
      cnt_d    = '0;
      fault_d  = 1'b0;
      fstage_d = 3'd0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (locked_s_q) begin
            state_d = S_DELAY;
            idx_d   = 3'd0;
            cnt_d   = '0;
          end
        end
        S_DELAY: begin
          if (cnt_q == DLY_LAST) begin
            for (int i = 0; i < NUM_STAGES; i++)
              if (idx_q == 3'(i)) rst_n_d[i] = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          // An ack on the timeout cycle still counts as success.
          if (ack_pad[idx_q]) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_READY;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = S_DELAY;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_d  = S_FAULT;
            fault_d  = 1'b1;
            fstage_d = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_READY: begin
          if (!(&stage_ack_i)) begin
            state_d  = S_FAULT;
            fault_d  = 1'b1;
            fstage_d = low_idx;
          end
        end
        S_FAULT: ;
        default: state_d = S_HOLD;
      endcase
    end

    if (state_d == S_HOLD || state_d == S_FAULT) rst_n_d = '0;
    ready_d = (state_d == S_READY);
    busy_d  = (state_d == S_HOLD) || (state_d == S_DELAY) || (state_d == S_WAIT_ACK);
  end

  assign stage_rst_n_o = rst_n_q;
  assign all_ready_o   = ready_q;
  assign seq_busy_o    = busy_q;
  assign fault_o       = fault_q;
  assign fault_stage_o = fstage_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with NUM_STAGES=4, STAGE_DELAY=4, ACK_TIMEOUT=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_req;
  logic [3:0] ack;
  logic [3:0] stage_rst_n;
  logic       all_ready, seq_busy, fault;
  logic [2:0] fault_stage;
  logic [9:0] obs;
  int         nvec = 0;
  int         nerr = 0;

  rst_sequencer #(.NUM_STAGES(4), .STAGE_DELAY(4), .ACK_TIMEOUT(16), .CNT_W(16)) dut (
    .sys_clk_i      (clk),
    .sys_rst_n_i    (rst_n),
    .pll_locked_i   (pll_locked),
    .soft_rst_req_i (soft_req),
    .stage_ack_i    (ack),
    .stage_rst_n_o  (stage_rst_n),
    .all_ready_o    (all_ready),
    .seq_busy_o     (seq_busy),
    .fault_o        (fault),
    .fault_stage_o  (fault_stage)
  );

  always #5 clk = ~clk;

  // {stage_rst_n, all_ready, seq_busy, fault, fault_stage}
  assign obs = {stage_rst_n, all_ready, seq_busy, fault, fault_stage};

  task automatic test_reset();
    logic [9:0] exp;
    rst_n = 1'b0; pll_locked = 1'b0; soft_req = 1'b0; ack = 4'b0000;
    repeat (3) @(negedge clk);
    exp = 10'b0000_0_0_0_000;
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL reset_state: got %b want %b", obs, exp); end
    rst_n = 1'b1;
    @(negedge clk);
    exp = {4'b0000, 1'b0, 1'b1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL reset_release_busy: got %b want %b", obs, exp); end
  endtask

  // Start from HOLD with the synchroniser holding 0. Raise lock, then release each stage.
  // 'miss' is a stage that never acks. 'late' is a stage that acks on the timeout cycle.
  // ef and efs give the fault flag and fault stage expected throughout the run.
  task automatic run_seq(input int miss, input int late, input logic ef, input logic [2:0] efs);
    logic [3:0] er;
    logic [9:0] exp;
    ack = 4'b0000;
    pll_locked = 1'b1;
    repeat (6) @(negedge clk);            // through edge N+5
    er = 4'b0000;
    exp = {er, 1'b0, 1'b1, ef, efs};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL seq_pre_release0: got %b want %b", obs, exp); end
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);                     // release edge R
      er[s] = 1'b1;
      exp = {er, 1'b0, 1'b1, ef, efs};
      nvec++;
      if (obs !== exp) begin nerr++; $display("FAIL seq_release%0d: got %b want %b", s, obs, exp); end
      if (s == miss) begin
        repeat (15) @(negedge clk);       // through R+15
        exp = {er, 1'b0, 1'b1, ef, efs};
        nvec++;
        if (obs !== exp) begin nerr++; $display("FAIL seq_pre_timeout: got %b want %b", obs, exp); end
        @(negedge clk);                   // R+16
        exp = {4'b0000, 1'b0, 1'b0, 1'b1, 3'(s)};
        nvec++;
        if (obs !== exp) begin nerr++; $display("FAIL seq_timeout_fault: got %b want %b", obs, exp); end
        return;
      end
      if (s == late) repeat (15) @(negedge clk);
      else repeat (2) @(negedge clk);
      ack[s] = 1'b1;
      @(negedge clk);                     // ack sampled
      if (s == 3) begin
        exp = {4'b1111, 1'b1, 1'b0, ef, efs};
        nvec++;
        if (obs !== exp) begin nerr++; $display("FAIL seq_ready: got %b want %b", obs, exp); end
      end else begin
        exp = {er, 1'b0, 1'b1, ef, efs};
        nvec++;
        if (obs !== exp) begin nerr++; $display("FAIL seq_ack%0d: got %b want %b", s, obs, exp); end
        repeat (3) @(negedge clk);        // one edge before the next release
        nvec++;
        if (obs !== exp) begin nerr++; $display("FAIL seq_delay%0d: got %b want %b", s + 1, obs, exp); end
      end
    end
  endtask

  // Drop lock long enough for the sequencer to reach HOLD.
  task automatic go_hold(input logic ef, input logic [2:0] efs);
    logic [9:0] exp;
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    ack = 4'b0000;
    exp = {4'b0000, 1'b0, 1'b1, ef, efs};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL go_hold: got %b want %b", obs, exp); end
  endtask

  task automatic test_lock_loss();
    logic [9:0] exp;
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);            // through M+1
    exp = {4'b1111, 1'b1, 1'b0, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL lockloss_latency: got %b want %b", obs, exp); end
    @(negedge clk);                       // M+2
    exp = {4'b0000, 1'b0, 1'b1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL lockloss_hold: got %b want %b", obs, exp); end
    repeat (2) @(negedge clk);            // lock held low for 5 edges in total
    run_seq(4, 4, 1'b0, 3'd0);
  endtask

  task automatic test_ack_timeout();
    logic [9:0] exp;
    go_hold(1'b0, 3'd0);
    run_seq(2, 4, 1'b0, 3'd0);
    soft_req = 1'b1;
    @(negedge clk);
    soft_req = 1'b0;
    exp = {4'b0000, 1'b0, 1'b1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL soft_clear: got %b want %b", obs, exp); end
    repeat (4) @(negedge clk);
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL soft_pre_release: got %b want %b", obs, exp); end
    @(negedge clk);
    exp = {4'b0001, 1'b0, 1'b1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL soft_restart0: got %b want %b", obs, exp); end
  endtask

  task automatic test_ack_at_timeout();
    go_hold(1'b0, 3'd0);
    run_seq(4, 1, 1'b0, 3'd0);
  endtask

  task automatic test_ready_ack_drop();
    logic [9:0] exp;
    go_hold(1'b0, 3'd0);
    run_seq(4, 4, 1'b0, 3'd0);
    ack = 4'b0101;
    @(negedge clk);
    exp = {4'b0000, 1'b0, 1'b0, 1'b1, 3'd1};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL ready_ack_drop: got %b want %b", obs, exp); end
  endtask

  task automatic test_fault_relock();
    go_hold(1'b1, 3'd1);
    run_seq(4, 4, 1'b1, 3'd1);
  endtask

  task automatic test_reset_mid_delay();
    logic [9:0] exp;
    go_hold(1'b1, 3'd1);
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);            // through N+3, inside DELAY
    rst_n = 1'b0;
    @(negedge clk);
    exp = 10'b0000_0_0_0_000;
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL reset_mid_delay: got %b want %b", obs, exp); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);            // through E6
    exp = {4'b0000, 1'b0, 1'b1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL post_reset_pre_release: got %b want %b", obs, exp); end
    @(negedge clk);                       // E7
    exp = {4'b0001, 1'b0, 1'b1, 1'b0, 3'd0};
    nvec++;
    if (obs !== exp) begin nerr++; $display("FAIL post_reset_release0: got %b want %b", obs, exp); end
  endtask

  initial begin
    test_reset();
    run_seq(4, 4, 1'b0, 3'd0);
    test_lock_loss();
    test_ack_timeout();
    test_ack_at_timeout();
    test_ready_ack_drop();
    test_fault_relock();
    test_reset_mid_delay();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Sits directly downstream of the system clock/reset generator, in the sys_clk domain.
- Takes the inverted global system reset and the PLL lock status, then releases per-subsystem resets one stage at a time.
- Before releasing the next stage it waits a programmable delay and an init-done acknowledge from the current stage.
- Flags a sticky fault on an acknowledge timeout or on acknowledge loss after bring-up.

Parameters:
- NUM_STAGES, 4, number of sequenced reset domains (1..8).
- STAGE_DELAY, 1024, sys_clk cycles from entering DELAY to that stage's reset release (>=1).
- ACK_TIMEOUT, 65535, max WAIT_ACK cycles before fault (>=1).
- CNT_W, 16, shared counter width; must hold max(STAGE_DELAY, ACK_TIMEOUT)-1.

Ports:
- sys_clk_i  in  1  system clock.
- sys_rst_n_i  in  1  synchronous, active-low reset.
- pll_locked_i  in  1  PLL lock status; double-flop synchronised internally to locked_s.
- soft_rst_req_i  in  1  single-cycle request for a full re-sequence; also clears fault.
- stage_ack_i  in  NUM_STAGES  per-stage init-done, level-sensitive.
- stage_rst_n_o  out  NUM_STAGES  per-stage active-low reset, registered.
- all_ready_o  out  1  high only in READY.
- seq_busy_o  out  1  high in HOLD, DELAY and WAIT_ACK.
- fault_o  out  1  sticky fault flag.
- fault_stage_o  out  3  index of the faulting stage.

Behaviour:
- Reset (sys_rst_n_i=0 at an edge): state HOLD, idx=0, cnt=0, sync flops 0. Outputs: stage_rst_n_o=0, all_ready_o=0, seq_busy_o=0, fault_o=0, fault_stage_o=0. seq_busy_o goes 1 on the first edge after reset release.
- All outputs are registered; no combinational path from any input to any output.
- States: HOLD, DELAY, WAIT_ACK, READY, FAULT.
- HOLD: all stage_rst_n_o=0. When locked_s=1: go to DELAY, cnt=0, idx=0.
- DELAY: cnt increments each cycle. At cnt==STAGE_DELAY-1: stage_rst_n_o[idx]<=1, cnt<=0, go to WAIT_ACK.
- WAIT_ACK:
  - If stage_ack_i[idx]=1: if idx==NUM_STAGES-1, go to READY (all_ready_o<=1); else idx++, cnt=0, go to DELAY.
  - Else if cnt==ACK_TIMEOUT-1: go to FAULT, fault_o<=1, fault_stage_o<=idx.
  - Else cnt++.
  - Ack and timeout in the same cycle: ack wins.
- Released stages stay released while later stages sequence. A stage's ack may drop during later stages' sequencing without effect.
- READY: if any stage_ack_i bit is 0, go to FAULT with fault_stage_o = lowest deasserted index.
- FAULT: all stage_rst_n_o<=0, all_ready_o<=0, seq_busy_o<=0. Held until soft_rst_req_i or locked loss.
- Global priority, in any state, evaluated every edge:
  1. locked_s=0 (outside HOLD): next edge stage_rst_n_o=0, all_ready_o=0, state HOLD, idx=0, cnt=0. fault_o is retained.
  2. soft_rst_req_i=1: same as above, and fault_o<=0, fault_stage_o<=0. In HOLD it only clears fault.
  3. Normal state logic.
- Lock latency: pll_locked_i sampled high at edge N gives locked_s=1 after edge N+1. HOLD exits at edge N+2, and stage_rst_n_o[0] rises after edge N+2+STAGE_DELAY.
- A locked glitch shorter than one cycle may be missed by the synchroniser; this is acceptable.
- Re-sequencing after HOLD always restarts from stage 0.
- No counter wrap: cnt is cleared on every state entry and stops at its terminal value.

Test Plan:
- NUM_STAGES=4, STAGE_DELAY=4, ACK_TIMEOUT=16. Drive sys_rst_n_i low 3 cycles then high, pll_locked_i high at edge N, each ack asserted 2 cycles after its reset release -> stage_rst_n_o[0] rises after edge N+6. Each later stage rises 4 cycles after the previous ack is sampled. all_ready_o=1 one edge after ack[3] is sampled. seq_busy_o=0 in READY.
- Same setup, stage_ack_i[2] never asserted -> 16 cycles after stage_rst_n_o[2] rises: fault_o=1, fault_stage_o=2, stage_rst_n_o=4'b0000. Then a soft_rst_req_i pulse -> fault_o=0 and sequencing restarts from stage 0.
- In READY, drop pll_locked_i for 5 cycles -> 2 edges later stage_rst_n_o=0 and all_ready_o=0. Full re-sequence runs after lock returns.
- In WAIT_ACK on stage 1, assert ack[1] on the exact cycle cnt==ACK_TIMEOUT-1 -> no fault; DELAY for stage 2 begins.
- In READY, drop stage_ack_i[1] and stage_ack_i[3] together -> fault_o=1, fault_stage_o=1.
- In FAULT, deassert lock and reassert it without a soft request -> sequence reruns and fault_o stays 1. Assert sys_rst_n_i=0 mid-DELAY -> all outputs at reset values on the next edge.
